uart_line_cond: RTL and testbench

Board-level receive-line conditioner between the UART RX pin and the SoC `UART_RXD` input. It synchronizes the asynchronous pin, rejects short glitches and presents a clean idle-high serial line to the SoC UART. It also detects a UART break, meaning the line is held low far longer than any character. Optionally, a detected break produces a stretched reset request; the board top ORs this request into the SoC `XRES`, so a host can force re-entry into the boot monitor.

---
 rtl/uart_line_cond_pkg.sv | 21 ++
 rtl/uart_line_cond_if.sv | 13 +
 rtl/uart_line_cond_rx_sync_filter.sv | 60 ++++++
 rtl/uart_line_cond.sv | 131 +++++++++++++
 tb/tb_uart_line_cond.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/uart_line_cond_pkg.sv
// Shared types and defaults for the UART receive-line conditioner.
package uart_line_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COUNT   = 2'd1,
      BREAK   = 2'd2,
      STRETCH = 2'd3
   } brk_state_e;

   localparam int unsigned SYNC_STAGES_DEF  = 2;
   localparam int unsigned FILT_LEN_DEF     = 4;
   localparam int unsigned BREAK_CYCLES_DEF = 1200000;
   localparam int unsigned RST_STRETCH_DEF  = 16;
   localparam int unsigned GLITCH_W         = 8;

   function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/uart_line_cond_if.sv
// Conditioned RX line bundle: raw pin in, filtered line / break status out.
interface uart_line_cond_if;
   import uart_line_pkg::*;

   logic                RXD_PIN;
   logic                RXD_OUT;
   logic                BRK;
   logic                BRK_RST;
   logic [GLITCH_W-1:0] GLITCHES;

   modport master (output RXD_PIN, input RXD_OUT, input BRK, input BRK_RST, input GLITCHES);
   modport slave  (input RXD_PIN, output RXD_OUT, output BRK, output BRK_RST, output GLITCHES);
endinterface

// File: rtl/uart_line_cond_rx_sync_filter.sv
// Pin synchronizer, consecutive-sample glitch filter and saturating glitch counter.
module rx_sync_filter
   import uart_line_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int unsigned FILT_LEN    = FILT_LEN_DEF
) (
   input  logic                XCLK,
   input  logic                XRES,
   input  logic                RXD_PIN,
   output logic                RXD_OUT,
   output logic [GLITCH_W-1:0] GLITCHES
);

   localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic [3:0]             fcnt_q, fcnt_d;
   logic                   rxd_q, rxd_d;
   logic [GLITCH_W-1:0]    glitch_q, glitch_d;

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge XCLK) begin
      if (XRES) begin
         sync_q   <= '1;
         fcnt_q   <= '0;
         rxd_q    <= 1'b1;
         glitch_q <= '0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], RXD_PIN};
         fcnt_q   <= fcnt_d;
         rxd_q    <= rxd_d;
         glitch_q <= glitch_d;
      end
   end

   // A level change must persist FILT_LEN filter cycles; an early return counts as one glitch.
   always_comb begin
      fcnt_d   = fcnt_q;
      rxd_d    = rxd_q;
      glitch_d = glitch_q;
      if (s != rxd_q) begin
         if (fcnt_q == FILT_LAST) begin
            rxd_d  = s;
            fcnt_d = '0;
         end else begin
            fcnt_d = fcnt_q + 4'd1;
         end
      end else if (fcnt_q != '0) begin
         fcnt_d   = '0;
         glitch_d = sat_inc(glitch_q);
      end
   end

   assign RXD_OUT  = rxd_q;
   assign GLITCHES = glitch_q;

endmodule

// File: rtl/uart_line_cond.sv
// UART RX line conditioner top: filtered line plus break detection.
// Define UART_BREAK_RESET_EN to build the stretched BRK_RST reset request.
module uart_line_cond
   import uart_line_pkg::*;
#(
   parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF,
   parameter int unsigned FILT_LEN     = FILT_LEN_DEF,
   parameter int unsigned BREAK_CYCLES = BREAK_CYCLES_DEF,
   parameter int unsigned RST_STRETCH  = RST_STRETCH_DEF
) (
   input logic            XCLK,
   input logic            XRES,
   uart_line_cond_if.slave line
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
      $error("SYNC_STAGES must be 2 or 3");
   end
   if (FILT_LEN < 1 || FILT_LEN > 16) begin : g_bad_filt
      $error("FILT_LEN must be 1..16");
   end
   if (BREAK_CYCLES < 1 || BREAK_CYCLES > 24'hFF_FFFF) begin : g_bad_break
      $error("BREAK_CYCLES must fit 24 bits and be nonzero");
   end
   if (RST_STRETCH < 1 || RST_STRETCH > 255) begin : g_bad_stretch
      $error("RST_STRETCH must be 1..255");
   end

   localparam logic [23:0] BRK_LAST = 24'(BREAK_CYCLES);

   logic       rxd;
   brk_state_e state_q, state_d;
   logic [23:0] bcnt_q, bcnt_d;
   logic        brk_q, brk_d;

   rx_sync_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
   ) u_filt (
      .XCLK     (XCLK),
      .XRES     (XRES),
      .RXD_PIN  (line.RXD_PIN),
      .RXD_OUT  (rxd),
      .GLITCHES (line.GLITCHES)
   );

`ifdef UART_BREAK_RESET_EN
   localparam logic [7:0] STR_LAST = 8'(RST_STRETCH - 1);
   logic [7:0] scnt_q, scnt_d;
   logic       brst_q, brst_d;
`endif

   always_ff @(posedge XCLK) begin
      if (XRES) begin
         state_q <= IDLE;
         bcnt_q  <= '0;
         brk_q   <= 1'b0;
`ifdef UART_BREAK_RESET_EN
         scnt_q  <= '0;
         brst_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         brk_q   <= brk_d;
`ifdef UART_BREAK_RESET_EN
         scnt_q  <= scnt_d;
         brst_q  <= brst_d;
`endif
      end
   end

   // Outputs are registered from the next state so BRK/BRK_RST move on the transition edge.
   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
`ifdef UART_BREAK_RESET_EN
      scnt_d  = scnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (!rxd) begin
               bcnt_d  = 24'd1;
               state_d = (BRK_LAST == 24'd1) ? BREAK : COUNT;
            end
         end
         COUNT: begin
            if (rxd) begin
               bcnt_d  = '0;
               state_d = IDLE;
            end else begin
               bcnt_d = bcnt_q + 24'd1;
               if (bcnt_q + 24'd1 == BRK_LAST) state_d = BREAK;
            end
         end
         BREAK: begin
            if (rxd) begin
               bcnt_d = '0;
`ifdef UART_BREAK_RESET_EN
               scnt_d  = '0;
               state_d = STRETCH;
`else
               state_d = IDLE;
`endif
            end
         end
         STRETCH: begin
`ifdef UART_BREAK_RESET_EN
            if (scnt_q == STR_LAST) state_d = IDLE;
            else                    scnt_d  = scnt_q + 8'd1;
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
      brk_d = (state_d == BREAK);
`ifdef UART_BREAK_RESET_EN
      brst_d = (state_d == BREAK) || (state_d == STRETCH);
`endif
   end

   assign line.RXD_OUT = rxd;
   assign line.BRK     = brk_q;
`ifdef UART_BREAK_RESET_EN
   assign line.BRK_RST = brst_q;
`else
   assign line.BRK_RST = 1'b0;
`endif

endmodule

// File: tb/tb_uart_line_cond.sv
// Scoreboard bench for uart_line_cond: expected output edges are queued per stimulus.
module tb_uart_line_cond;
   import uart_line_pkg::*;

   localparam int unsigned SYNC = 2;
   localparam int unsigned FILT = 4;
   localparam int unsigned BRKC = 100;
   localparam int unsigned STR  = 16;
   localparam int unsigned LAT  = SYNC + FILT;
`ifdef UART_BREAK_RESET_EN
   localparam bit BRST_EN = 1'b1;
`else
   localparam bit BRST_EN = 1'b0;
`endif

   typedef struct {
      int unsigned cyc;
      logic [2:0]  vec;   // {RXD_OUT, BRK, BRK_RST}
   } ev_t;

   logic        XCLK = 1'b0;
   logic        XRES = 1'b1;
   ev_t         sb_q[$];
   int unsigned cyc = 0;
   int unsigned n_tests = 0;
   int unsigned n_fail = 0;
   int unsigned exp_gl = 0;
   bit          mon_en = 1'b0;
   logic [2:0]  prev;

   uart_line_cond_if line ();

   uart_line_cond #(
      .SYNC_STAGES  (SYNC),
      .FILT_LEN     (FILT),
      .BREAK_CYCLES (BRKC),
      .RST_STRETCH  (STR)
   ) dut (
      .XCLK (XCLK),
      .XRES (XRES),
      .line (line)
   );

   always #5 XCLK = ~XCLK;
   always @(posedge XCLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic void push(input int unsigned c, input logic [2:0] v);
      ev_t e;
      e.cyc = c;
      e.vec = v;
      sb_q.push_back(e);
   endfunction

   // Every observed output change must match the next queued event in cycle and value.
   always @(negedge XCLK) begin : mon
      logic [2:0] v;
      ev_t        e;
      if (mon_en) begin
         v = {line.RXD_OUT, line.BRK, line.BRK_RST};
         if (v !== prev) begin
            if (sb_q.size() == 0) begin
               check("unexpected_change", 32'(v), 32'(prev));
            end else begin
               e = sb_q.pop_front();
               check("event_cycle", e.cyc == 0 ? 32'(cyc) : 32'(cyc), 32'(e.cyc));
               check("event_value", 32'(v), 32'(e.vec));
            end
            prev = v;
         end
      end
   end

   task automatic pulse_low(input int unsigned len, input int unsigned gap, input bit rst_mid);
      int unsigned f, s_cyc;
      @(negedge XCLK);
      line.RXD_PIN = 1'b0;
      f = cyc + LAT;
      if (len >= FILT) begin
         push(f, 3'b000);
         if (len >= BRKC) begin
            push(f + BRKC, {2'b01, BRST_EN});
            push(f + len, {2'b11, BRST_EN});
            push(f + len + 1, {2'b10, BRST_EN});
            if (BRST_EN && !rst_mid) push(f + len + 1 + STR, 3'b100);
         end else begin
            push(f + len, 3'b100);
         end
      end else begin
         exp_gl = (exp_gl < 255) ? exp_gl + 1 : 255;
      end
      repeat (len) @(negedge XCLK);
      line.RXD_PIN = 1'b1;
      if (rst_mid) begin
         s_cyc = f + len + 1;
         while (cyc < s_cyc + 5) @(negedge XCLK);
         XRES = 1'b1;
         if (BRST_EN) push(cyc + 1, 3'b100);
         @(negedge XCLK);
         XRES = 1'b0;
         exp_gl = 0;
      end
      repeat (gap) @(negedge XCLK);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int unsigned n;
      line.RXD_PIN = 1'b0;
      XRES = 1'b1;
      repeat (3) @(negedge XCLK);
      check("rst_rxd_out",  32'(line.RXD_OUT), 32'd1);
      check("rst_brk",      32'(line.BRK), 32'd0);
      check("rst_brk_rst",  32'(line.BRK_RST), 32'd0);
      check("rst_glitches", 32'(line.GLITCHES), 32'd0);

      // Pin held low through reset: RXD_OUT falls at the 6th edge after release.
      XRES = 1'b0;
      n = cyc;
      prev = {line.RXD_OUT, line.BRK, line.BRK_RST};
      mon_en = 1'b1;
      push(n + LAT, 3'b000);
      repeat (10) @(negedge XCLK);
      line.RXD_PIN = 1'b1;
      push(n + 10 + LAT, 3'b100);
      repeat (12) @(negedge XCLK);

      pulse_low(3, 10, 1'b0);
      check("glitch_3", 32'(line.GLITCHES), 32'(exp_gl));
      pulse_low(4, 12, 1'b0);
      check("accept_4", 32'(line.GLITCHES), 32'(exp_gl));
      pulse_low(1, 10, 1'b0);
      pulse_low(7, 12, 1'b0);
      check("glitch_1_accept_7", 32'(line.GLITCHES), 32'(exp_gl));

      for (int i = 0; i < 300; i++) pulse_low(2, 2, 1'b0);
      repeat (8) @(negedge XCLK);
      check("saturate", 32'(line.GLITCHES), 32'(exp_gl));
      pulse_low(2, 10, 1'b0);
      check("saturate_hold", 32'(line.GLITCHES), 32'd255);

      pulse_low(200, 40, 1'b0);
      check("break_gl", 32'(line.GLITCHES), 32'(exp_gl));
      check("break_idle_brk", 32'(line.BRK), 32'd0);

      pulse_low(200, 40, 1'b1);
      check("mid_rst_brk_rst", 32'(line.BRK_RST), 32'd0);
      check("mid_rst_gl", 32'(line.GLITCHES), 32'(exp_gl));

      pulse_low(5, 12, 1'b0);
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
